series_sched: RTL and testbench

- Scheduler and controller for the shared Maclaurin-series datapath (x/T/E registers, multiplier, reciprocal ROM, accumulator).
- Arbitrates round-robin among NREQ requesters. Each requester selects exp, sin or cos.
- Sequences the per-term multiply / reciprocal-multiply / accumulate steps for NTERMS terms, then returns a done pulse to the granted requester.
- Sits between the requester front-ends and the single datapath instance.

---
 rtl/series_sched_pkg.sv | 52 +++++
 rtl/series_sched_rr_arbiter.sv | 28 ++
 rtl/series_sched.sv | 154 +++++++++++++++
 tb/tb_series_sched.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/series_sched_pkg.sv
// Shared types and constants for the Maclaurin-series scheduler: FSM states,
// function codes and the fixed per-state datapath strobes.
package series_sched_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      MX1  = 3'd2,
      MR1  = 3'd3,
      MX2  = 3'd4,
      MR2  = 3'd5,
      ACC  = 3'd6,
      DONE = 3'd7
   } state_t;

   localparam logic [1:0] FN_EXP = 2'd0;
   localparam logic [1:0] FN_SIN = 2'd1;
   localparam logic [1:0] FN_COS = 2'd2;
   localparam logic [1:0] FN_BAD = 2'd3;

   // Strobes that depend on the state alone; function-dependent bits
   // (initSel, subE, recipIdx) are decoded in the top.
   typedef struct packed {
      logic ldX;
      logic initT;
      logic initE;
      logic selXR;
      logic ldT;
      logic ldE;
   } ctrl_t;

   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         LOAD: begin
            c.ldX   = 1'b1;
            c.initT = 1'b1;
            c.initE = 1'b1;
         end
         MX1, MX2: begin
            c.selXR = 1'b1;
            c.ldT   = 1'b1;
         end
         MR1, MR2: c.ldT = 1'b1;
         ACC:      c.ldE = 1'b1;
         default:  c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/series_sched_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot winner is the first requester
// found scanning upward from the pointer, wrapping modulo NREQ.
module rr_arbiter
   import series_sched_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] win_o
);

   logic found;

   // Scan from the pointer, keep only the first hit.
   always_comb begin
      win_o = '0;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req_i[(int'(ptr_i) + i) % NREQ]) begin
            win_o[(int'(ptr_i) + i) % NREQ] = 1'b1;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/series_sched.sv
// Scheduler for the shared Maclaurin-series datapath: arbitrates among
// requesters, then steps multiply / reciprocal-multiply / accumulate for
// NTERMS terms and pulses done back to the granted requester.
module series_sched
   import series_sched_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int NTERMS = 8,
   parameter int CW     = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [2*NREQ-1:0] func,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic              err,
   output logic              busy,
   output logic              ldX,
   output logic              initT,
   output logic              initE,
   output logic              initSel,
   output logic              selXR,
   output logic              ldT,
   output logic              ldE,
   output logic              subE,
   output logic [CW-1:0]     recipIdx
);

   localparam int KW = $clog2(NTERMS + 1);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [1:0]      fn_q, fn_d;

   logic [NREQ-1:0] win;
   logic [PW-1:0]   win_idx;
   logic [1:0]      fn_win;
   ctrl_t           ctrl;
   logic [CW-1:0]   kx, k2;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req_i (req),
      .ptr_i (ptr_q),
      .win_o (win)
   );

   // Encode the one-hot winner and pick its function code.
   always_comb begin
      win_idx = '0;
      fn_win  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win[i]) begin
            win_idx = PW'(i);
            fn_win  = func[2*i +: 2];
         end
      end
   end

   // Next-state logic: grant capture in IDLE, term loop, completion.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      fn_d    = fn_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               gnt_d   = win;
               fn_d    = fn_win;
               ptr_d   = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
               state_d = (fn_win == FN_BAD) ? DONE : LOAD;
            end
         end
         LOAD: begin
            k_d     = KW'(1);
            state_d = MX1;
         end
         MX1:  state_d = MR1;
         MR1:  state_d = (fn_q == FN_EXP) ? ACC : MX2;
         MX2:  state_d = MR2;
         MR2:  state_d = ACC;
         ACC: begin
            if (k_q == KW'(NTERMS)) begin
               state_d = DONE;
            end else begin
               k_d     = k_q + KW'(1);
               state_d = MX1;
            end
         end
         DONE: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset aborts any operation and rewinds the pointer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         ptr_q   <= '0;
         gnt_q   <= '0;
         fn_q    <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         fn_q    <= fn_d;
      end
   end

   // Moore decode of state, term counter and latched function.
   always_comb begin
      ctrl     = state_ctrl(state_q);
      ldX      = ctrl.ldX;
      initT    = ctrl.initT;
      initE    = ctrl.initE;
      selXR    = ctrl.selXR;
      ldT      = ctrl.ldT;
      ldE      = ctrl.ldE;
      initSel  = (state_q == LOAD) && (fn_q == FN_SIN);
      subE     = (state_q == ACC) && (fn_q != FN_EXP) && k_q[0];
      gnt      = gnt_q;
      done     = (state_q == DONE) ? gnt_q : '0;
      err      = (state_q == DONE) && (fn_q == FN_BAD);
      busy     = (state_q != IDLE);
      kx       = CW'(k_q);
      k2       = kx << 1;
      recipIdx = '0;
      if (state_q == MR1) begin
         case (fn_q)
            FN_EXP:  recipIdx = kx;
            FN_SIN:  recipIdx = k2;
            FN_COS:  recipIdx = k2 - CW'(1);
            default: recipIdx = '0;
         endcase
      end else if (state_q == MR2) begin
         case (fn_q)
            FN_SIN:  recipIdx = k2 + CW'(1);
            FN_COS:  recipIdx = k2;
            default: recipIdx = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_series_sched.sv
// Bench for series_sched: a term-level series model predicts every output
// each cycle, and directed scenarios pin latency, ROM index order, subtract
// pattern, arbitration order, illegal codes and reset abort.
module tb_series_sched;

   localparam int NREQ   = 4;
   localparam int NTERMS = 8;
   localparam int CW     = 5;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [3:0]      req = '0;
   logic [7:0]      func = '0;
   logic [3:0]      gnt, done;
   logic            err, busy, ldX, initT, initE, initSel, selXR, ldT, ldE, subE;
   logic [CW-1:0]   recipIdx;

   typedef logic [22:0] vec_t;
   vec_t dut_vec;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   series_sched #(.NREQ(NREQ), .NTERMS(NTERMS), .CW(CW)) dut (
      .clk(clk), .rst(rst), .req(req), .func(func),
      .gnt(gnt), .done(done), .err(err), .busy(busy),
      .ldX(ldX), .initT(initT), .initE(initE), .initSel(initSel),
      .selXR(selXR), .ldT(ldT), .ldE(ldE), .subE(subE), .recipIdx(recipIdx)
   );

   always #5 clk = ~clk;

   assign dut_vec = {gnt, done, err, busy, ldX, initT, initE, initSel,
                     selXR, ldT, ldE, subE, recipIdx};

   // ---------------- behavioural model ----------------
   vec_t q[$];
   vec_t cur = '0;
   int   m_ptr = 0;

   function automatic vec_t mk(logic [3:0] g, logic [3:0] d, logic e,
                               logic lx, logic ini, logic isel, logic sx,
                               logic lt, logic le, logic se, int r);
      return {g, d, e, 1'b1, lx, ini, ini, isel, sx, lt, le, se, 5'(r)};
   endfunction

   // One operation as the list of cycles it occupies after the grant.
   // Term k multiplies T by x/k (exp), x*x/((2k)(2k+1)) (sin) or
   // x*x/((2k-1)(2k)) (cos), then adds or subtracts T into E.
   task automatic build(input int w, input int c);
      logic [3:0] g;
      g = 4'(1 << w);
      if (c == 3) begin
         q.push_back(mk(g, g, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0));
         return;
      end
      q.push_back(mk(g, 4'b0, 1'b0, 1, 1, (c == 1), 0, 0, 0, 0, 0));
      for (int k = 1; k <= NTERMS; k++) begin
         int d1, d2;
         d1 = (c == 0) ? k : (c == 1) ? 2 * k : 2 * k - 1;
         d2 = (c == 1) ? 2 * k + 1 : 2 * k;
         q.push_back(mk(g, 4'b0, 1'b0, 0, 0, 0, 1, 1, 0, 0, 0));
         q.push_back(mk(g, 4'b0, 1'b0, 0, 0, 0, 0, 1, 0, 0, d1));
         if (c != 0) begin
            q.push_back(mk(g, 4'b0, 1'b0, 0, 0, 0, 1, 1, 0, 0, 0));
            q.push_back(mk(g, 4'b0, 1'b0, 0, 0, 0, 0, 1, 0, 0, d2));
         end
         q.push_back(mk(g, 4'b0, 1'b0, 0, 0, 0, 0, 0, 1, (c != 0) && (k % 2 == 1), 0));
      end
      q.push_back(mk(g, g, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
         cur   = '0;
         m_ptr = 0;
      end else if (q.size() > 0) begin
         cur = q.pop_front();
      end else if (cur[13]) begin
         cur = '0;
      end else if (req != 4'b0) begin
         int  w;
         bit  found;
         w = 0;
         found = 1'b0;
         for (int i = 0; i < NREQ; i++) begin
            if (!found && req[(m_ptr + i) % NREQ]) begin
               w = (m_ptr + i) % NREQ;
               found = 1'b1;
            end
         end
         m_ptr = (w + 1) % NREQ;
         build(w, int'(func[2*w +: 2]));
         cur = q.pop_front();
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if (dut_vec !== cur) begin
            failures++;
            $display("FAIL cycle_outputs t=%0t dut=%h model=%h", $time, dut_vec, cur);
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp_v);
      end
   endtask

   task automatic chk_seq(input string nm, input int act[$], input int exp_q[$]);
      chk({nm, "_len"}, act.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < act.size(); i++)
         chk($sformatf("%s_%0d", nm, i), act[i], exp_q[i]);
   endtask

   int rec_q[$];
   int sub_q[$];
   int ld_seen;
   int isel_seen;
   int err_seen;

   task automatic run_single(input int idx, input int code, input int lat_exp, input string nm);
      int  n;
      bit  got;
      rec_q.delete();
      sub_q.delete();
      ld_seen   = 0;
      isel_seen = -1;
      err_seen  = 0;
      got       = 1'b0;
      @(posedge clk); #1;
      func[2*idx +: 2] = 2'(code);
      req[idx]         = 1'b1;
      for (n = 0; n < 200; n++) begin
         @(negedge clk);
         if (n == 1) chk({nm, "_gnt"}, int'(gnt), 1 << idx);
         if (ldT && !selXR) rec_q.push_back(int'(recipIdx));
         if (ldE) sub_q.push_back(int'(subE));
         if (ldX) isel_seen = int'(initSel);
         if (ldX || ldT || ldE) ld_seen++;
         if (done[idx]) begin
            got = 1'b1;
            err_seen = int'(err);
            break;
         end
      end
      chk({nm, "_latency"}, got ? n : -1, lat_exp);
      @(posedge clk); #1;
      req[idx] = 1'b0;
   endtask

   task automatic reset_pulse();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int order[$];
      int w, n, acc_cnt;
      bit got, saw_done2;

      // Reset state
      repeat (2) @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      chk("reset_outputs", int'(dut_vec), 0);
      #1 rst = 1'b1;

      // Single exp on requester 0
      run_single(0, 0, 2 + 3 * NTERMS, "exp0");
      chk_seq("exp0_recip", rec_q, '{1, 2, 3, 4, 5, 6, 7, 8});
      chk_seq("exp0_subE", sub_q, '{0, 0, 0, 0, 0, 0, 0, 0});
      chk("exp0_err", err_seen, 0);

      // Single sin on requester 2
      run_single(2, 1, 2 + 5 * NTERMS, "sin2");
      chk("sin2_initSel", isel_seen, 1);
      chk_seq("sin2_recip", rec_q, '{2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17});
      chk_seq("sin2_subE", sub_q, '{1, 0, 1, 0, 1, 0, 1, 0});

      // Single cos on requester 1
      run_single(1, 2, 2 + 5 * NTERMS, "cos1");
      chk("cos1_initSel", isel_seen, 0);
      chk_seq("cos1_recip", rec_q, '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16});
      chk_seq("cos1_subE", sub_q, '{1, 0, 1, 0, 1, 0, 1, 0});

      // All four requesting exp at once from a fresh pointer
      reset_pulse();
      @(posedge clk); #1;
      func = 8'h00;
      req  = 4'b1111;
      for (int op = 0; op < 5; op++) begin
         got = 1'b0;
         w   = -1;
         for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done != 4'b0) begin
               got = 1'b1;
               chk($sformatf("rr_done_eq_gnt_%0d", op), int'(done), int'(gnt));
               for (int i = 0; i < NREQ; i++) if (done[i]) w = i;
               break;
            end
         end
         if (!got) chk($sformatf("rr_timeout_%0d", op), 0, 1);
         order.push_back(w);
         @(posedge clk); #1;
         if (w >= 0) req[w] = 1'b0;
         if (op == 2) begin
            repeat (5) @(posedge clk);
            #1 req[0] = 1'b1;
         end
      end
      chk_seq("rr_order", order, '{0, 1, 2, 3, 0});

      // Illegal code on requester 3
      run_single(3, 3, 1, "bad3");
      chk("bad3_err", err_seen, 1);
      chk("bad3_no_datapath", ld_seen, 0);
      func = 8'h00;

      // Reset during the fifth accumulate of an exp on requester 2
      @(posedge clk); #1;
      req = 4'b0100;
      repeat (3) @(posedge clk);
      #1 req = 4'b1110;
      acc_cnt   = 0;
      saw_done2 = 1'b0;
      for (n = 0; n < 200 && acc_cnt < 5; n++) begin
         @(negedge clk);
         if (ldE) acc_cnt++;
      end
      chk("abort_reached_acc5", acc_cnt, 5);
      #2 rst = 1'b0;
      #1 chk("abort_async_outputs", int'(dut_vec), 0);
      req = 4'b1010;
      @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_regrant", int'(gnt), 4'b0010);
      got = 1'b0;
      for (n = 0; n < 200; n++) begin
         @(negedge clk);
         if (done[2]) saw_done2 = 1'b1;
         if (done[1]) begin
            got = 1'b1;
            break;
         end
      end
      chk("abort_regrant_done", int'(got), 1);
      chk("abort_no_done2", int'(saw_done2), 0);
      @(posedge clk); #1;
      req = 4'b0000;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("final_idle_busy", int'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
